iseq_loader: RTL and testbench

Upstream stage of `iseq_dispatcher`: accepts a host instruction stream, splits it into the two instruction FIFOs the dispatcher drains, and launches execution. Instructions alternate between FIFO0 and FIFO1. An END word pads odd-length sequences and pulses `process_iseq`. The loader then holds off the host until the dispatcher finishes.

---
 rtl/iseq_loader.sv | 140 ++++++++++++++
 tb/tb_iseq_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/iseq_loader.sv
// Host-side instruction loader: splits a word stream alternately into two FWFT FIFOs,
// pads odd sequences, launches the dispatcher and waits for it to go idle again.
module iseq_loader #(
   parameter int          FIFO_AW   = 10,
   parameter logic [3:0]  END_CODE  = 4'hF,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [31:0]        in_data,
   output logic               in_ready,
   output logic               process_iseq,
   input  logic               dispatcher_busy,
   input  logic               instr0_fifo_rd,
   input  logic               instr1_fifo_rd,
   output logic               instr0_fifo_empty,
   output logic               instr1_fifo_empty,
   output logic [31:0]        instr0_fifo_data,
   output logic [31:0]        instr1_fifo_data,
   output logic [FIFO_AW+1:0] seq_len,
   output logic               overflow,
   output logic               iseq_done
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int LW    = FIFO_AW + 2;
   localparam logic [LW-1:0] LEN_MAX = LW'(2 * DEPTH);

   typedef enum logic [2:0] {LOAD, PAD, START, WAIT_BUSY, RUN} state_t;
   state_t state, state_nxt;

   logic [31:0]      mem0 [DEPTH];
   logic [31:0]      mem1 [DEPTH];
   logic [FIFO_AW:0] wptr0, rptr0, wptr1, rptr1;
   logic             full0, full1, pop0, pop1, push0, push1;
   logic             sel, launched;
   logic             is_end, word_acc, drop, pushed;
   logic [31:0]      wdata1;
   logic [LW-1:0]    len_base;

   function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
      return (v >= LEN_MAX) ? v : v + 1'b1;
   endfunction

   assign instr0_fifo_empty = (wptr0 == rptr0);
   assign instr1_fifo_empty = (wptr1 == rptr1);
   assign full0 = (wptr0[FIFO_AW] != rptr0[FIFO_AW]) &&
                  (wptr0[FIFO_AW-1:0] == rptr0[FIFO_AW-1:0]);
   assign full1 = (wptr1[FIFO_AW] != rptr1[FIFO_AW]) &&
                  (wptr1[FIFO_AW-1:0] == rptr1[FIFO_AW-1:0]);
   assign pop0 = instr0_fifo_rd & ~instr0_fifo_empty;
   assign pop1 = instr1_fifo_rd & ~instr1_fifo_empty;
   assign instr0_fifo_data = mem0[rptr0[FIFO_AW-1:0]];
   assign instr1_fifo_data = mem1[rptr1[FIFO_AW-1:0]];

   assign is_end   = (in_data[31:28] == END_CODE);
   assign word_acc = in_valid & (state == LOAD) & ~is_end;
   assign drop     = word_acc & (sel ? full1 : full0);
   assign pushed   = push0 | push1;
   // A finished launch leaves seq_len/overflow visible until the next sequence starts
   assign len_base = launched ? '0 : seq_len;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOAD;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      in_ready     = 1'b0;
      process_iseq = 1'b0;
      iseq_done    = 1'b0;
      push0        = 1'b0;
      push1        = 1'b0;
      wdata1       = in_data;
      case (state)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (is_end) begin
                  if (len_base != '0) state_nxt = sel ? PAD : START;
               end else begin
                  push0 = ~sel & ~full0;
                  push1 = sel & ~full1;
               end
            end
         end
         PAD: begin
            push1     = 1'b1;
            wdata1    = NOP_INSTR;
            state_nxt = START;
         end
         START: begin
            process_iseq = 1'b1;
            state_nxt    = WAIT_BUSY;
         end
         WAIT_BUSY: if (dispatcher_busy) state_nxt = RUN;
         RUN: begin
            if (!dispatcher_busy) begin
               iseq_done = 1'b1;
               state_nxt = LOAD;
            end
         end
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr0    <= '0;
         rptr0    <= '0;
         wptr1    <= '0;
         rptr1    <= '0;
         sel      <= 1'b0;
         launched <= 1'b0;
         seq_len  <= '0;
         overflow <= 1'b0;
      end else begin
         if (push0) wptr0 <= wptr0 + 1'b1;
         if (push1) wptr1 <= wptr1 + 1'b1;
         if (pop0)  rptr0 <= rptr0 + 1'b1;
         if (pop1)  rptr1 <= rptr1 + 1'b1;
         if (word_acc) begin
            launched <= 1'b0;
            seq_len  <= pushed ? sat_inc(len_base) : len_base;
            overflow <= (overflow & ~launched) | drop;
            if (pushed) sel <= ~sel;
         end else if (state == PAD) begin
            seq_len <= sat_inc(seq_len);
            sel     <= 1'b0;
         end
         if (state == START) launched <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push0) mem0[wptr0[FIFO_AW-1:0]] <= in_data;
      if (push1) mem1[wptr1[FIFO_AW-1:0]] <= wdata1;
   end
endmodule

// File: tb/tb_iseq_loader.sv
// Directed bench for iseq_loader with 4-deep FIFOs: padding, launch handshake,
// empty END, overflow drops and asynchronous reset while running.
module tb_iseq_loader;
   localparam int AW = 2;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [31:0]   in_data = '0;
   logic          in_ready, process_iseq, iseq_done, overflow;
   logic          dispatcher_busy = 1'b0;
   logic          rd0 = 1'b0, rd1 = 1'b0;
   logic          empty0, empty1;
   logic [31:0]   data0, data1;
   logic [AW+1:0] seq_len;

   int vectors = 0;
   int miscompares = 0;

   iseq_loader #(.FIFO_AW(AW), .END_CODE(4'hF), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .process_iseq(process_iseq),
      .dispatcher_busy(dispatcher_busy),
      .instr0_fifo_rd(rd0), .instr1_fifo_rd(rd1),
      .instr0_fifo_empty(empty0), .instr1_fifo_empty(empty1),
      .instr0_fifo_data(data0), .instr1_fifo_data(data1),
      .seq_len(seq_len), .overflow(overflow), .iseq_done(iseq_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] w);
      in_valid = 1'b1;
      in_data  = w;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pop_both();
      rd0 = 1'b1;
      rd1 = 1'b1;
      tick();
      rd0 = 1'b0;
      rd1 = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_process", process_iseq, 0);
      chk("rst_done", iseq_done, 0);
      chk("rst_empty0", empty0, 1);
      chk("rst_empty1", empty1, 1);
      chk("rst_seq_len", seq_len, 0);
      chk("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      tick();

      // Empty END right after reset: ignored
      send(32'hF000_0000);
      chk("end0_process", process_iseq, 0);
      chk("end0_ready", in_ready, 1);

      // Odd sequence A B C + END
      send(32'hA000_000A);
      chk("a_visible_empty0", empty0, 0);
      chk("a_visible_data0", data0, 32'hA000_000A);
      send(32'hB000_000B);
      send(32'hC000_000C);
      send(32'hF123_4567);
      chk("odd_pad_ready", in_ready, 0);
      chk("odd_pad_process", process_iseq, 0);
      tick();
      chk("odd_start_process", process_iseq, 1);
      chk("odd_seq_len", seq_len, 4);
      tick();
      chk("odd_process_off", process_iseq, 0);
      chk("odd_h0_a", data0, 32'hA000_000A);
      chk("odd_h1_b", data1, 32'hB000_000B);
      pop_both();
      chk("odd_h0_c", data0, 32'hC000_000C);
      chk("odd_h1_nop", data1, NOP);
      chk("odd_nonempty1", empty1, 0);
      pop_both();
      chk("odd_empty0", empty0, 1);
      chk("odd_empty1", empty1, 1);
      dispatcher_busy = 1'b1;
      tick();
      dispatcher_busy = 1'b0;
      #1;
      chk("odd_done", iseq_done, 1);
      tick();
      chk("odd_done_off", iseq_done, 0);
      chk("odd_ready_back", in_ready, 1);

      // Even sequence of four words, dispatcher busy for 10 cycles
      send(32'h1000_0001);
      chk("even_len_restart", seq_len, 1);
      send(32'h2000_0002);
      send(32'h3000_0003);
      send(32'h4000_0004);
      send(32'hF000_0000);
      chk("even_start_process", process_iseq, 1);
      chk("even_seq_len", seq_len, 4);
      tick();
      chk("even_process_off", process_iseq, 0);
      dispatcher_busy = 1'b1;
      tick();
      chk("even_h0_w0", data0, 32'h1000_0001);
      chk("even_h1_w1", data1, 32'h2000_0002);
      pop_both();
      chk("even_h0_w2", data0, 32'h3000_0003);
      chk("even_h1_w3", data1, 32'h4000_0004);
      pop_both();
      for (int i = 0; i < 7; i++) begin
         chk("even_busy_no_done", iseq_done, 0);
         tick();
      end
      dispatcher_busy = 1'b0;
      #1;
      chk("even_done", iseq_done, 1);
      tick();
      chk("even_done_off", iseq_done, 0);
      chk("even_ready_back", in_ready, 1);
      chk("even_empty0", empty0, 1);
      chk("even_empty1", empty1, 1);

      // END after a completed launch with no new words: ignored
      send(32'hF000_0000);
      chk("end1_process", process_iseq, 0);
      chk("end1_ready", in_ready, 1);
      tick();
      chk("end1_process_later", process_iseq, 0);

      // Ten words into 4+4 capacity: words 9 and 10 dropped
      for (int i = 1; i <= 8; i++) send(32'h0000_0100 + 32'(i));
      chk("ovf_len8", seq_len, 8);
      chk("ovf_clear8", overflow, 0);
      send(32'h0000_0109);
      chk("ovf_set9", overflow, 1);
      chk("ovf_len9", seq_len, 8);
      send(32'h0000_010A);
      chk("ovf_len10", seq_len, 8);
      send(32'hF000_0000);
      chk("ovf_start_process", process_iseq, 1);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("ovf_head0", data0, 32'h0000_0101 + 32'(2 * k));
         chk("ovf_head1", data1, 32'h0000_0102 + 32'(2 * k));
         pop_both();
      end
      chk("ovf_empty0", empty0, 1);
      chk("ovf_empty1", empty1, 1);
      dispatcher_busy = 1'b1;
      tick();
      dispatcher_busy = 1'b0;
      tick();
      chk("ovf_ready_back", in_ready, 1);

      // Five words (3 in FIFO0), launch, reset while in RUN
      for (int i = 1; i <= 5; i++) send(32'h0000_0200 + 32'(i));
      chk("rst_run_ovf_cleared", overflow, 0);
      send(32'hF000_0000);
      tick();
      chk("rst_run_process", process_iseq, 1);
      tick();
      dispatcher_busy = 1'b1;
      tick();
      chk("rst_run_ready", in_ready, 0);
      chk("rst_run_fill0", empty0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_run_empty0", empty0, 1);
      chk("rst_run_empty1", empty1, 1);
      chk("rst_run_in_ready", in_ready, 1);
      chk("rst_run_seq_len", seq_len, 0);
      dispatcher_busy = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_run_after_ready", in_ready, 1);
      chk("rst_run_after_empty0", empty0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
